// File: rtl/adc_cap_pkg.sv
// Shared constants and helpers for the ADC serial capture bank.
package adc_cap_pkg;

    // Default bank geometry for the SAR front end.
    localparam int DEF_NUM_CH = 8;
    localparam int DEF_DATA_W = 10;

    // Bit-order selector for the serial stream.
    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

    // Width of a bit counter that must reach dw-1. Never narrower than one bit.
    function automatic int cnt_w(input int dw);
        return (dw <= 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/adc_capture_chan.sv
// One capture channel: serial shift register, bit counter, holding register
// with valid/ack handshake and sticky overrun flag.
module adc_capture_chan
    import adc_cap_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_bit,
    input  logic              en,
    input  logic              restart,
    input  logic              ack,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun,
    output logic              busy
);

    localparam int              CNT_W = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_next;
    logic [CNT_W-1:0]  cnt;
    logic              shift;
    logic              complete;

    // Restart outranks the shift enable, so a restart cycle never samples adc_bit.
    assign shift    = en && !restart;
    assign complete = shift && (cnt == LAST);

    // The completed word includes the bit arriving on this cycle.
    if (MSB_FIRST) begin : g_msb
        assign sh_next = {sh[DATA_W-2:0], adc_bit};
    end else begin : g_lsb
        assign sh_next = {adc_bit, sh[DATA_W-1:1]};
    end

    // Shift register and bit counter; both return to zero on restart or completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (restart) begin
            sh  <= '0;
            cnt <= '0;
        end else if (shift) begin
            if (cnt == LAST) begin
                sh  <= '0;
                cnt <= '0;
            end else begin
                sh  <= sh_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Holding register loads only on completion, independent of restart activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (complete) begin
            data <= sh_next;
        end
    end

    // Valid: completion wins over ack so a same-cycle ack never drops a fresh word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (complete) begin
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun: a word lost to overwrite is flagged; setting beats clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (complete && valid && !ack) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/adc_capture_bank.sv
// Bank of independent serial-to-parallel capture channels sharing one ADC bit line.
module adc_capture_bank
    import adc_cap_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adc_bit,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        ch_restart,
    input  logic [NUM_CH-1:0]        ack,
    input  logic [NUM_CH-1:0]        ovr_clr,
    output logic [NUM_CH*DATA_W-1:0] data,
    output logic [NUM_CH-1:0]        valid,
    output logic [NUM_CH-1:0]        overrun,
    output logic [NUM_CH-1:0]        busy
);

    // Every channel sees the same adc_bit; ch_en selects which ones sample it.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        adc_capture_chan #(
            .DATA_W    (DATA_W),
            .MSB_FIRST (MSB_FIRST)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .adc_bit (adc_bit),
            .en      (ch_en[i]),
            .restart (ch_restart[i]),
            .ack     (ack[i]),
            .ovr_clr (ovr_clr[i]),
            .data    (data[i*DATA_W +: DATA_W]),
            .valid   (valid[i]),
            .overrun (overrun[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_adc_capture_bank.sv
// Directed bench for adc_capture_bank: an MSB-first bank and an LSB-first bank
// driven from the same stimulus.
module tb_adc_capture_bank;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 10;
    localparam int BUS_W  = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              adc_bit;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_restart;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] ovr_clr;

    logic [BUS_W-1:0]  data_m,    data_l;
    logic [NUM_CH-1:0] valid_m,   valid_l;
    logic [NUM_CH-1:0] overrun_m, overrun_l;
    logic [NUM_CH-1:0] busy_m,    busy_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_capture_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .adc_bit(adc_bit), .ch_en(ch_en),
        .ch_restart(ch_restart), .ack(ack), .ovr_clr(ovr_clr),
        .data(data_m), .valid(valid_m), .overrun(overrun_m), .busy(busy_m)
    );

    adc_capture_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .adc_bit(adc_bit), .ch_en(ch_en),
        .ch_restart(ch_restart), .ack(ack), .ovr_clr(ovr_clr),
        .data(data_l), .valid(valid_l), .overrun(overrun_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first nbits of w starting at w[9]. ack/ovr_clr masks apply on the last bit.
    task automatic send(input logic [DATA_W-1:0] w, input logic [NUM_CH-1:0] en, input int nbits,
                        input bit gaps, input logic [NUM_CH-1:0] ack_last,
                        input logic [NUM_CH-1:0] clr_last);
        for (int i = 0; i < nbits; i++) begin
            adc_bit = w[DATA_W-1-i];
            ch_en   = en;
            if (i == nbits - 1) begin
                ack     = ack_last;
                ovr_clr = clr_last;
            end
            tick();
            ch_en   = '0;
            ack     = '0;
            ovr_clr = '0;
            if (gaps) tick();
        end
        adc_bit = 1'b0;
    endtask

    initial begin
        // Reset with garbage on every input
        rst_n = 1'b0; adc_bit = 1'b1; ch_en = '1; ch_restart = 8'hA5; ack = '1; ovr_clr = '1;
        repeat (3) tick();
        chk("reset_data",    data_m,            '0);
        chk("reset_valid",   BUS_W'(valid_m),   '0);
        chk("reset_overrun", BUS_W'(overrun_m), '0);
        chk("reset_busy",    BUS_W'(busy_m),    '0);

        rst_n = 1'b1; adc_bit = 1'b0; ch_en = '0; ch_restart = '0; ack = '0; ovr_clr = '0;
        tick();

        // Ch0 word 1,0,1,1,0,0,1,0,1,1 split 5+5 to see busy mid-word
        send(10'h2CB, 8'h01, 5, 1'b0, 8'h00, 8'h00);
        chk("ch0_busy_mid", BUS_W'(busy_m), BUS_W'(8'h01));
        send(10'h2CB << 5, 8'h01, 5, 1'b0, 8'h00, 8'h00);
        chk("ch0_msb_word", BUS_W'(data_m[9:0]), BUS_W'(10'h2CB));
        chk("ch0_lsb_word", BUS_W'(data_l[9:0]), BUS_W'(10'h34D));
        chk("ch0_valid",    BUS_W'(valid_m), BUS_W'(8'h01));
        chk("ch0_busy_end", BUS_W'(busy_m),  '0);
        chk("ch0_others",   BUS_W'(data_m[BUS_W-1:DATA_W]), '0);
        ack = 8'h01; tick(); ack = '0;
        chk("ch0_ack", BUS_W'(valid_m), '0);
        ack = 8'h01; tick(); ack = '0;
        chk("ack_no_valid", BUS_W'(valid_m), '0);

        // Ch3 with gaps between every bit
        send(10'h2CB, 8'h08, 3, 1'b1, 8'h00, 8'h00);
        chk("ch3_busy_gap", BUS_W'(busy_m), BUS_W'(8'h08));
        send(10'h2CB << 3, 8'h08, 7, 1'b1, 8'h00, 8'h00);
        chk("ch3_gap_word", BUS_W'(data_m[3*DATA_W +: DATA_W]), BUS_W'(10'h2CB));
        ack = 8'h08; tick(); ack = '0;
        // Restart after 5 bits with ch_en also high that cycle
        send(10'h3FF, 8'h08, 5, 1'b0, 8'h00, 8'h00);
        ch_restart = 8'h08; ch_en = 8'h08; adc_bit = 1'b1; tick();
        ch_restart = '0; ch_en = '0; adc_bit = 1'b0;
        chk("ch3_restart_busy", BUS_W'(busy_m), '0);
        chk("ch3_restart_keep", BUS_W'(data_m[3*DATA_W +: DATA_W]), BUS_W'(10'h2CB));
        send(10'h0F0, 8'h08, 10, 1'b0, 8'h00, 8'h00);
        chk("ch3_fresh_word", BUS_W'(data_m[3*DATA_W +: DATA_W]), BUS_W'(10'h0F0));
        chk("ch3_no_ovr",     BUS_W'(overrun_m), '0);

        // Ch1 overrun: two words, no ack
        send(10'h111, 8'h02, 10, 1'b0, 8'h00, 8'h00);
        send(10'h2AA, 8'h02, 10, 1'b0, 8'h00, 8'h00);
        chk("ch1_ovr_data", BUS_W'(data_m[DATA_W +: DATA_W]), BUS_W'(10'h2AA));
        chk("ch1_ovr_set",  BUS_W'(overrun_m), BUS_W'(8'h02));
        ovr_clr = 8'h02; tick(); ovr_clr = '0;
        chk("ch1_ovr_clr",   BUS_W'(overrun_m), '0);
        chk("ch1_valid_kept", BUS_W'(valid_m), BUS_W'(8'h0A));
        // Completion together with ack: no overrun
        send(10'h3C3, 8'h02, 10, 1'b0, 8'h02, 8'h00);
        chk("ch1_ack_same_data", BUS_W'(data_m[DATA_W +: DATA_W]), BUS_W'(10'h3C3));
        chk("ch1_ack_same_vld",  BUS_W'(valid_m),   BUS_W'(8'h0A));
        chk("ch1_ack_same_ovr",  BUS_W'(overrun_m), '0);
        // Overrun set beats clear in the same cycle
        send(10'h001, 8'h02, 10, 1'b0, 8'h00, 8'h02);
        chk("ch1_set_beats_clr", BUS_W'(overrun_m), BUS_W'(8'h02));

        ack = '1; ovr_clr = '1; tick(); ack = '0; ovr_clr = '0;
        chk("all_acked", BUS_W'(valid_m), '0);

        // Broadcast to all channels
        send(10'h155, 8'hFF, 10, 1'b0, 8'h00, 8'h00);
        chk("bcast_data_m", data_m, {NUM_CH{10'h155}});
        chk("bcast_data_l", data_l, {NUM_CH{10'h2AA}});
        chk("bcast_valid",  BUS_W'(valid_m), BUS_W'(8'hFF));
        chk("bcast_ovr",    BUS_W'(overrun_m), '0);
        ack = 8'h0F; tick(); ack = '0;
        chk("bcast_ack", BUS_W'(valid_m), BUS_W'(8'hF0));

        // Ch5 mid-word, then synchronous reset
        send(10'h3FF, 8'h20, 4, 1'b0, 8'h00, 8'h00);
        chk("ch5_busy", BUS_W'(busy_m), BUS_W'(8'h20));
        rst_n = 1'b0;
        #2;
        chk("rst_no_edge_valid", BUS_W'(valid_m), BUS_W'(8'hF0));
        chk("rst_no_edge_busy",  BUS_W'(busy_m),  BUS_W'(8'h20));
        tick();
        chk("rst_mid_data",  data_m,           '0);
        chk("rst_mid_valid", BUS_W'(valid_m),  '0);
        chk("rst_mid_busy",  BUS_W'(busy_m),   '0);
        chk("rst_mid_ovr",   BUS_W'(overrun_m | overrun_l | busy_l | valid_l), '0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
